// File: rtl/wb_select_hilo.sv
// wb_select_hilo: writeback select stage owning the HI/LO registers and MDU busy.
// Optional same-cycle HI/LO write-through: define WB_HILO_BYPASS_EN.
module wb_select_hilo #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = $clog2(NUM_SRC + 2)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     mt_hi_en,
    input  logic                     mt_lo_en,
    input  logic [WIDTH-1:0]         mt_data,
    input  logic                     mdu_start,
    input  logic                     mdu_done,
    input  logic [WIDTH-1:0]         mdu_hi,
    input  logic [WIDTH-1:0]         mdu_lo,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     sel_err,
    output logic [WIDTH-1:0]         hi_q,
    output logic [WIDTH-1:0]         lo_q,
    output logic                     mdu_busy
);

    localparam logic [SEL_W-1:0] SEL_HI = SEL_W'(NUM_SRC);
    localparam logic [SEL_W-1:0] SEL_LO = SEL_W'(NUM_SRC + 1);

    logic             sel_src;
    logic             sel_hi;
    logic             sel_lo;
    logic             sel_bad;
    logic             hilo_hazard;
    logic             accept;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] hi_rd;
    logic [WIDTH-1:0] lo_rd;
    logic [WIDTH-1:0] src_mux;
    logic [WIDTH-1:0] rd_data;

    assign sel_src = (sel < SEL_HI);
    assign sel_hi  = (sel == SEL_HI);
    assign sel_lo  = (sel == SEL_LO);
    assign sel_bad = (sel > SEL_LO);

    // MT writes come later in program order, so they override MDU results
    assign hi_next = mt_hi_en ? mt_data :
                     mdu_done ? mdu_hi  : hi_q;
    assign lo_next = mt_lo_en ? mt_data :
                     mdu_done ? mdu_lo  : lo_q;

`ifdef WB_HILO_BYPASS_EN
    assign hi_rd       = hi_next;
    assign lo_rd       = lo_next;
    assign hilo_hazard = (sel_hi | sel_lo) & mdu_busy & ~mdu_done;
`else
    assign hi_rd       = hi_q;
    assign lo_rd       = lo_q;
    assign hilo_hazard = (sel_hi | sel_lo) & mdu_busy;
`endif

    assign in_ready = ~stall & ~hilo_hazard;
    assign accept   = in_valid & in_ready;

    // Pick the general datapath source addressed by sel
    always_comb begin
        src_mux = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                src_mux = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Final writeback value; invalid selects read as zero
    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            sel_src: rd_data = src_mux;
            sel_hi:  rd_data = hi_rd;
            sel_lo:  rd_data = lo_rd;
            default: rd_data = '0;
        endcase
    end

    // HI/LO architectural registers, updated regardless of stall
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_next;
            lo_q <= lo_next;
        end
    end

    // MDU busy: a start in the done cycle keeps the unit busy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mdu_busy <= 1'b0;
        end else if (mdu_start) begin
            mdu_busy <= 1'b1;
        end else if (mdu_done) begin
            mdu_busy <= 1'b0;
        end
    end

    // Writeback pipeline register with stall hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
                sel_err   <= sel_bad;
            end else begin
                out_valid <= 1'b0;
                sel_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_select_hilo.sv
// tb_wb_select_hilo: directed plus randomized checks of wb_select_hilo
// against a behavioural model of the HI/LO and writeback rules.
module tb_wb_select_hilo;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int SW = $clog2(N + 2);
`ifdef WB_HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] src_data;
    logic [W-1:0]   src [N];
    logic [SW-1:0]  sel;
    logic           in_valid;
    logic           in_ready;
    logic           stall;
    logic           mt_hi_en;
    logic           mt_lo_en;
    logic [W-1:0]   mt_data;
    logic           mdu_start;
    logic           mdu_done;
    logic [W-1:0]   mdu_hi;
    logic [W-1:0]   mdu_lo;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           sel_err;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           mdu_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_hi, m_lo, m_out;
    bit           m_busy, m_valid, m_err;

    assign src_data = {src[2], src[1], src[0]};

    always #5 clk = ~clk;

    wb_select_hilo #(.WIDTH(W), .NUM_SRC(N)) dut (
        .clk(clk), .reset_n(reset_n), .src_data(src_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .mt_hi_en(mt_hi_en), .mt_lo_en(mt_lo_en), .mt_data(mt_data),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
        .out_data(out_data), .out_valid(out_valid), .sel_err(sel_err),
        .hi_q(hi_q), .lo_q(lo_q), .mdu_busy(mdu_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        sel       = '0;
        stall     = 1'b0;
        mt_hi_en  = 1'b0;
        mt_lo_en  = 1'b0;
        mt_data   = '0;
        mdu_start = 1'b0;
        mdu_done  = 1'b0;
        mdu_hi    = '0;
        mdu_lo    = '0;
    endtask

    function automatic bit reads_hilo();
        int s = int'(sel);
        return (s == N) || (s == N + 1);
    endfunction

    function automatic bit exp_ready();
        bit blocked = reads_hilo() && m_busy && !(BYP && mdu_done);
        return !stall && !blocked;
    endfunction

    // One clock: check in_ready, advance the model, check all outputs
    task automatic cyc();
        logic [W-1:0] n_hi, n_lo, rhi, rlo, val;
        bit           rdy;
        int           s;
        #1;
        rdy = exp_ready();
        chk("in_ready", in_ready, rdy);
        s = int'(sel);
        n_hi = mdu_done ? mdu_hi : m_hi;
        if (mt_hi_en) n_hi = mt_data;
        n_lo = mdu_done ? mdu_lo : m_lo;
        if (mt_lo_en) n_lo = mt_data;
        rhi = BYP ? n_hi : m_hi;
        rlo = BYP ? n_lo : m_lo;
        if (s < N)           val = src[s];
        else if (s == N)     val = rhi;
        else if (s == N + 1) val = rlo;
        else                 val = '0;
        @(posedge clk);
        if (!reset_n) begin
            m_hi = '0; m_lo = '0; m_busy = 0;
            m_out = '0; m_valid = 0; m_err = 0;
        end else begin
            m_hi = n_hi;
            m_lo = n_lo;
            if (mdu_start)     m_busy = 1;
            else if (mdu_done) m_busy = 0;
            if (!stall) begin
                if (in_valid && rdy) begin
                    m_out = val; m_valid = 1; m_err = (s > N + 1);
                end else begin
                    m_valid = 0; m_err = 0;
                end
            end
        end
        #1;
        chk("out_data", out_data, m_out);
        chk("out_valid", out_valid, m_valid);
        chk("sel_err", sel_err, m_err);
        chk("hi_q", hi_q, m_hi);
        chk("lo_q", lo_q, m_lo);
        chk("mdu_busy", mdu_busy, m_busy);
        @(negedge clk);
    endtask

    initial begin
        foreach (src[i]) src[i] = '0;
        idle();
        m_hi = '0; m_lo = '0; m_out = '0;
        m_busy = 0; m_valid = 0; m_err = 0;
        @(negedge clk);

        // reset then select source 1
        reset_n = 1'b0;
        mdu_start = 1'b1;
        repeat (2) cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", mdu_busy, 0);
        idle();
        src[1] = 32'h1234_5678; sel = 1; in_valid = 1;
        cyc();
        chk("sel1_data", out_data, 32'h1234_5678);
        chk("sel1_valid", out_valid, 1);
        chk("sel1_err", sel_err, 0);

        // invalid select
        sel = 7;
        cyc();
        chk("bad_valid", out_valid, 1);
        chk("bad_data", out_data, 0);
        chk("bad_err", sel_err, 1);

        // stall hold
        src[0] = 32'hA; sel = 0;
        cyc();
        sel = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_rdy", in_ready, 0);
            cyc();
            chk("stall_data", out_data, 32'hA);
            chk("stall_valid", out_valid, 1);
        end
        idle();
        cyc();
        chk("unstall_valid", out_valid, 0);

        // MDU hazard on a HI read
        mdu_start = 1;
        cyc();
        idle();
        for (int c = 1; c <= 5; c++) begin
            sel = SW'(N); in_valid = 1;
            mdu_done = (c == 4);
            mdu_hi = 32'hDEAD; mdu_lo = 32'hBEEF;
            #1 chk("haz_rdy", in_ready, BYP ? (c >= 4) : (c >= 5));
            cyc();
            if (c == 4) begin
                chk("haz_c4_valid", out_valid, BYP);
                if (BYP) chk("haz_c4_data", out_data, 32'hDEAD);
            end
        end
        chk("haz_c5_data", out_data, 32'hDEAD);
        chk("haz_c5_valid", out_valid, 1);
        idle();

        // MT vs MDU collision
        mt_hi_en = 1; mt_data = 32'h1;
        mdu_done = 1; mdu_hi = 32'h2; mdu_lo = 32'h3;
        cyc();
        chk("coll_hi", hi_q, 32'h1);
        chk("coll_lo", lo_q, 32'h3);
        idle();

        // start and done together
        mdu_start = 1;
        cyc();
        mdu_done = 1;
        cyc();
        chk("sd_busy", mdu_busy, 1);
        idle();
        mdu_done = 1;
        cyc();
        chk("done_busy", mdu_busy, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset_n   = ($urandom_range(0, 40) != 0);
            foreach (src[k]) src[k] = $urandom;
            sel       = SW'($urandom_range(0, 7));
            in_valid  = $urandom_range(0, 3) != 0;
            stall     = $urandom_range(0, 3) == 0;
            mt_hi_en  = $urandom_range(0, 7) == 0;
            mt_lo_en  = $urandom_range(0, 7) == 0;
            mt_data   = $urandom;
            mdu_start = $urandom_range(0, 7) == 0;
            mdu_done  = $urandom_range(0, 5) == 0;
            mdu_hi    = $urandom;
            mdu_lo    = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
